// File: rtl/data_mem_wait.sv
// Byte-addressed data memory with a request/response handshake and a fixed
// response latency. Byte, half and word accesses are supported. Misaligned,
// out-of-range and illegal-size requests return an error response and leave
// the memory untouched.
module data_mem_wait #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-2:0] DEPTH_L = (ADDR_W-1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic              cap_we;
    logic [1:0]        cap_size;
    logic              cap_unsigned;
    logic [ADDR_W-1:0] cap_addr;
    logic [31:0]       cap_wdata;

    logic [31:0] mem [DEPTH_WORDS];

    logic              a_we;
    logic [1:0]        a_size;
    logic              a_unsigned;
    logic [ADDR_W-1:0] a_addr;
    logic [31:0]       a_wdata;
    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              a_err;
    logic              enter_resp;
    logic [31:0]       rword;
    logic [31:0]       wword;
    logic [31:0]       ld_data;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;

    assign req_ready = (state == IDLE) && reset;
    assign rsp_valid = (state == RESP);

    // Access fields: with LATENCY=1 or an error the edge entering RESP is the
    // acceptance edge itself, so the live request is used in IDLE and the
    // captured copy otherwise.
    always_comb begin
        if (state == IDLE) begin
            a_we       = req_we;
            a_size     = req_size;
            a_unsigned = req_unsigned;
            a_addr     = req_addr;
            a_wdata    = req_wdata;
        end else begin
            a_we       = cap_we;
            a_size     = cap_size;
            a_unsigned = cap_unsigned;
            a_addr     = cap_addr;
            a_wdata    = cap_wdata;
        end
    end

    // Legality checks, array lookup, lane merge for stores and load extension
    always_comb begin
        word_idx = a_addr[ADDR_W-1:2];
        mem_idx  = a_addr[IDX_W+1:2];
        a_err    = ({1'b0, word_idx} >= DEPTH_L)
                || (a_size == 2'b11)
                || (a_size == 2'b01 && a_addr[0])
                || (a_size == 2'b10 && a_addr[1:0] != 2'b00);
        rword  = mem[mem_idx];
        lane_b = rword[{a_addr[1:0], 3'b000} +: 8];
        lane_h = rword[{a_addr[1], 4'b0000} +: 16];
        wword  = rword;
        case (a_size)
            2'b00:   wword[{a_addr[1:0], 3'b000} +: 8] = a_wdata[7:0];
            2'b01:   wword[{a_addr[1], 4'b0000} +: 16] = a_wdata[15:0];
            default: wword = a_wdata;
        endcase
        case (a_size)
            2'b00:   ld_data = a_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   ld_data = a_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: ld_data = rword;
        endcase
    end

    // Next-state logic and latency counter
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (a_err || LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd1) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        enter_resp = (state_nxt == RESP) && (state != RESP);
    end

    // State, request capture and registered response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            cap_we       <= 1'b0;
            cap_size     <= '0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && req_valid) begin
                cap_we       <= req_we;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
            end
            if (enter_resp) begin
                rsp_err   <= a_err;
                rsp_rdata <= (a_err || a_we) ? '0 : ld_data;
            end else if (state == RESP && rsp_ready) begin
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    // Memory array: cleared on reset, store commits on the edge entering RESP
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (enter_resp && a_we && !a_err) begin
            mem[mem_idx] <= wword;
        end
    end

endmodule

// File: tb/tb_data_mem_wait.sv
// Self-checking bench for data_mem_wait: directed scenarios plus randomized
// traffic compared against a byte-array reference model.
module tb_data_mem_wait;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 64;
    localparam int LAT    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mb [4*DEPTH];

    data_mem_wait #(
        .ADDR_W(ADDR_W),
        .DEPTH_WORDS(DEPTH),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
    endtask

    // Reference: memory as a flat byte array, access legality from first principles
    task automatic model_access(input logic we, input logic [1:0] sz, input logic un,
                                input logic [31:0] ad, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
        int nb;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || ((ad % nb) != 0) || ((ad / 4) >= DEPTH);
        rd = '0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < nb; i++) mb[ad + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (32'(mb[ad + i]) << (8*i));
            if (!un && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd = v;
        end
    endtask

    task automatic send(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, output logic ok);
        int k;
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = req_ready;
        if (ok) @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) lat = -1;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [31:0] exp_rd, output logic exp_er);
        logic ok;
        rsp_ready = 1'b1;
        rd = 'x; er = 1'bx;
        send(we, sz, un, ad, wd, ok);
        model_access(we, sz, un, ad, wd, exp_rd, exp_er);
        if (!ok) begin
            lat = -1;
            return;
        end
        wait_rsp(lat);
        if (lat < 0) return;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        reset = 1'b0;
        model_clear();
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_hold: ready=%b valid=%b required 0 0", req_ready, rsp_valid);
            end
        end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_out: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== LAT) begin
            n_fail++;
            $display("FAIL rst_load: rdata=%h err=%b lat=%0d required 0 0 %0d", rd, er, lat, LAT);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        xact(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, rd, er, lat, erd, eer);
        n_checks++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL st_word: lat=%0d err=%b rdata=%h required %0d 0 0", lat, er, rd, LAT);
        end
        xact(1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (lat !== LAT || er !== 1'b0 || rd !== 32'hFFFFFFDE) begin
            n_fail++;
            $display("FAIL ld_sbyte: lat=%0d err=%b rdata=%h required %0d 0 ffffffde", lat, er, rd, LAT);
        end
        xact(1'b0, 2'd0, 1'b1, 32'h08, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h000000EF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_ubyte: rdata=%h err=%b required 000000ef 0", rd, er);
        end
        xact(1'b1, 2'd1, 1'b0, 32'h0A, 32'h1234, rd, er, lat, erd, eer);
        xact(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h1234BEEF || er !== 1'b0) begin
            n_fail++;
            $display("FAIL ld_merge: rdata=%h err=%b required 1234beef 0", rd, er);
        end
        xact(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h00001234) begin
            n_fail++;
            $display("FAIL ld_shalf: rdata=%h required 00001234", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        xact(1'b1, 2'd2, 1'b0, 32'h04, 32'h55667788, rd, er, lat, erd, eer);
        xact(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL err_word: lat=%0d err=%b rdata=%h required 1 1 0", lat, er, rd);
        end
        xact(1'b1, 2'd1, 1'b0, 32'h05, 32'hFFFF, rd, er, lat, erd, eer);
        n_checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL err_half: lat=%0d err=%b rdata=%h required 1 1 0", lat, er, rd);
        end
        xact(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL err_size: lat=%0d err=%b rdata=%h required 1 1 0", lat, er, rd);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h55667788 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL err_nochg: rdata=%h err=%b required 55667788 0", rd, er);
        end
        xact(1'b1, 2'd2, 1'b0, 32'h100, 32'hA5A5A5A5, rd, er, lat, erd, eer);
        n_checks++;
        if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL err_range: lat=%0d err=%b rdata=%h required 1 1 0", lat, er, rd);
        end
        xact(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL range_alias: rdata=%h err=%b required 0 0", rd, er);
        end
        xact(1'b1, 2'd2, 1'b0, 32'hFC, 32'hCAFEF00D, rd, er, lat, erd, eer);
        xact(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== LAT) begin
            n_fail++;
            $display("FAIL top_word: rdata=%h err=%b lat=%0d required cafef00d 0 %0d", rd, er, lat, LAT);
        end
    endtask

    task automatic test_stall();
        logic ok;
        logic [31:0] erd, first;
        logic eer;
        int lat;
        rsp_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, ok);
        model_access(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, erd, eer);
        wait_rsp(lat);
        n_checks++;
        if (!ok || lat !== LAT) begin
            n_fail++;
            $display("FAIL stall_lat: accepted=%b lat=%0d required 1 %0d", ok, lat, LAT);
        end
        first = rsp_rdata;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== erd || rsp_rdata !== first) begin
                n_fail++;
                $display("FAIL stall_hold: cyc=%0d valid=%b ready=%b rdata=%h required 1 0 %h",
                         c, rsp_valid, req_ready, rsp_rdata, erd);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [31:0] rd, erd;
        logic er, eer;
        int lat;
        send(1'b1, 2'd2, 1'b0, 32'h20, 32'hAAAA5555, ok);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL mid_rst: cyc=%0d valid=%b ready=%b required 0 1", c, rsp_valid, req_ready);
            end
        end
        xact(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, erd, eer);
        n_checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst_mem: rdata=%h err=%b required 0 0", rd, er);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd, ad, wd;
        logic er, eer;
        logic [1:0] sz;
        int lat;
        for (int i = 0; i < 8; i++) begin
            sz = 2'($urandom_range(0, 2));
            ad = $urandom_range(0, DEPTH - 1) * 4 + ((sz == 2'd0) ? $urandom_range(0, 3) :
                                                    (sz == 2'd1) ? 2 * $urandom_range(0, 1) : 0);
            wd = $urandom;
            xact(1'b1, sz, 1'b0, ad, wd, rd, er, lat, erd, eer);
            xact(1'b0, sz, 1'($urandom), ad, 32'h0, rd, er, lat, erd, eer);
            n_checks++;
            if (rd !== erd || er !== 1'b0 || lat !== LAT) begin
                n_fail++;
                $display("FAIL b2b: addr=%h size=%0d rdata=%h err=%b lat=%0d required %h 0 %0d",
                         ad, sz, rd, er, lat, erd, LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, ad;
        logic er, eer, we;
        logic [1:0] sz;
        int lat, elat;
        for (int i = 0; i < 60; i++) begin
            we = 1'($urandom);
            sz = 2'($urandom);
            ad = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH + 7));
            xact(we, sz, 1'($urandom), ad, $urandom, rd, er, lat, erd, eer);
            elat = eer ? 1 : LAT;
            n_checks++;
            if (rd !== erd || er !== eer || lat !== elat) begin
                n_fail++;
                $display("FAIL rand: we=%b addr=%h size=%0d rdata=%h err=%b lat=%0d required %h %b %0d",
                         we, ad, sz, rd, er, lat, erd, eer, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_errors();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_mem_wait.md
Name: data_mem_wait

Overview:
- Parametrised, byte-addressed data memory for the RISC-V core, replacing the word-only, zero-latency data memory.
- Supports byte/half/word loads and stores with sign/zero extension.
- Uses a request/response handshake with configurable read/write latency, so the core stalls on the memory.
- Detects misaligned and out-of-range accesses and returns an error response instead of corrupting state.

Parameters:
- ADDR_W, 32, request address width in bits.
- DEPTH_WORDS, 64, number of 32-bit words; must be a power of 2 and at least 4.
- LATENCY, 2, cycles from request acceptance to rsp_valid for legal accesses; legal range 1 to 15.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 resets on the next rising clk edge).
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  out  1  response is an error (misaligned, out of range, or illegal size).

Behaviour:
- Reset (reset=0 at a clk edge):
  - FSM goes to IDLE.
  - req_ready=0 during the reset cycle, then 1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All DEPTH_WORDS words cleared to 0.
  - Reset mid-operation drops the in-flight request; no write is performed if the write had not yet committed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, the request is accepted at that edge and its fields are captured.
    - Legal request with LATENCY=1 goes to RESP.
    - Legal request with LATENCY>1 goes to WAIT with counter=LATENCY-1.
    - Error request always goes to RESP after exactly 1 cycle.
  - WAIT: req_ready=0. Counter decrements each cycle; at counter==1 the next state is RESP.
  - RESP: req_ready=0, rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_ready=1. The handshake completes at that edge and the FSM returns to IDLE.
  - No request is accepted in the same cycle a response completes, so the minimum gap between acceptances is LATENCY+1 cycles.
- Legality checks, all evaluated on the captured request:
  - word_idx = addr[ADDR_W-1:2].
  - Out of range: word_idx >= DEPTH_WORDS.
  - Misaligned: size=01 with addr[0]=1, or size=10 with addr[1:0]!=00.
  - size=11 is an error.
  - Any error sets rsp_err=1 and rsp_rdata=0; memory is never modified.
- Stores:
  - Commit on the edge entering RESP, so memory changes exactly LATENCY cycles after acceptance.
  - Byte store writes lane addr[1:0] (lane 0 = bits [7:0], little-endian).
  - Half store writes lanes {addr[1],0} and {addr[1],1}.
  - Word store writes all four lanes.
  - Unwritten lanes are preserved.
  - Response: rsp_err=0, rsp_rdata=0.
- Loads:
  - Data is sampled from the array on the edge entering RESP and registered; rsp_rdata comes straight from a flop.
  - Byte/half loads select the lane(s) as for stores, then sign- or zero-extend per req_unsigned.
  - req_unsigned is ignored for word loads.
- Single outstanding request only; no internal buffering.
- Input changes while not in IDLE are ignored.
- Back-to-back store then load to the same address: the load observes the stored data, which is guaranteed by the single-outstanding rule.

Test Plan:
1. Reset held low for 2 cycles, then released → req_ready=1 on the first cycle after release, rsp_valid=0, and a word load from 0x10 returns 0x00000000 with rsp_err=0.
2. LATENCY=2: word store 0xDEADBEEF to 0x08, then byte load (signed) from 0x0B → rsp_valid asserts exactly 2 cycles after each acceptance; load returns 0xFFFFFFDE. Unsigned byte load from 0x08 returns 0x000000EF.
3. Half store 0x1234 to 0x0A over the existing 0xDEADBEEF, then word load from 0x08 → returns 0x1234BEEF.
4. Word load from 0x06, half store to 0x05, and a load with size=11 → each gives rsp_err=1 and rsp_rdata=0 one cycle after acceptance; a word load from 0x04 afterwards shows memory unchanged.
5. DEPTH_WORDS=64: word store to 0x100 → rsp_err=1 and no array word changes. Word store to 0xFC succeeds, and a load from 0xFC returns the stored value.
6. Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stay stable and req_ready=0 throughout. Then assert reset=0 mid-WAIT on a store → FSM returns to IDLE, no response is issued, and the target word reads 0.
